// File: rtl/multi_alarm_fsm.sv
// Mode/alarm controller: field editing, N-channel alarm match, ring and bounded snooze.
// Optional ring auto-timeout is built when MULTI_ALARM_RING_TIMEOUT_EN is defined.
module multi_alarm_fsm #(
    parameter int N_ALARMS     = 2,
    parameter int SNOOZE_SECS  = 30,
    parameter int MAX_SNOOZE   = 3,
    parameter int RING_TIMEOUT = 60
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tick_sec,
    input  logic                            btn_up,
    input  logic                            btn_down,
    input  logic                            btn_left,
    input  logic                            btn_right,
    input  logic                            btn_center,
    input  logic [4:0]                      time_h,
    input  logic [5:0]                      time_m,
    input  logic [5:0]                      time_s,
    input  logic [5*N_ALARMS-1:0]           alarm_h,
    input  logic [6*N_ALARMS-1:0]           alarm_m,
    input  logic [N_ALARMS-1:0]             alarm_arm,
    output logic                            adjust,
    output logic [3:0]                      edit_en,
    output logic [$clog2(N_ALARMS)-1:0]     sel_alarm,
    output logic                            ring,
    output logic                            snoozing,
    output logic [$clog2(N_ALARMS)-1:0]     ring_id,
    output logic [$clog2(MAX_SNOOZE+1)-1:0] snooze_left
);

    localparam int SW = $clog2(N_ALARMS);
    localparam int LW = $clog2(MAX_SNOOZE + 1);
    localparam int CW = $clog2(SNOOZE_SECS);

    localparam logic [SW-1:0] SEL_MAX  = SW'(N_ALARMS - 1);
    localparam logic [LW-1:0] SNZ_INIT = LW'(MAX_SNOOZE);
    localparam logic [CW-1:0] SNZ_LAST = CW'(SNOOZE_SECS - 1);

    if (N_ALARMS < 2 || SNOOZE_SECS < 2 || MAX_SNOOZE < 1 || RING_TIMEOUT < 2) begin : g_param_err
        $error("multi_alarm_fsm: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_TH,
        S_TM,
        S_AH,
        S_AM,
        S_CLOCK,
        S_RING,
        S_SNOOZE
    } state_t;

    state_t        state, state_n;
    logic [SW-1:0] sel_n, rid_n, hit_id;
    logic [LW-1:0] left_n;
    logic [CW-1:0] snz_cnt, snz_cnt_n;
    logic          fired, fired_n;
    logic          hit, match, snz_req;
    logic          any_dir, any_btn;
    logic [3:0]    edit_n;

`ifdef MULTI_ALARM_RING_TIMEOUT_EN
    localparam int RW = $clog2(RING_TIMEOUT);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT - 1);

    logic [RW-1:0] ring_cnt, ring_cnt_n;
`endif

    assign any_dir = btn_up | btn_down | btn_left | btn_right;
    assign any_btn = any_dir | btn_center;

    // Scan high to low so the lowest armed matching channel is kept.
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (alarm_arm[i] &&
                alarm_h[i*5 +: 5] == time_h &&
                alarm_m[i*6 +: 6] == time_m) begin
                hit    = 1'b1;
                hit_id = SW'(i);
            end
        end
        match = hit && (time_s == 6'd0) && !fired;
    end

    always_comb begin
        state_n   = state;
        sel_n     = sel_alarm;
        rid_n     = ring_id;
        left_n    = snooze_left;
        snz_cnt_n = snz_cnt;
        snz_req   = 1'b0;
        fired_n   = (time_s != 6'd0) ? 1'b0 : fired;
`ifdef MULTI_ALARM_RING_TIMEOUT_EN
        ring_cnt_n = ring_cnt;
`endif
        case (state)
            S_TH: begin
                if (btn_right) begin
                    state_n = S_TM;
                end else if (btn_left) begin
                    state_n = S_AM;
                    sel_n   = SEL_MAX;
                end else if (btn_center) begin
                    state_n = S_CLOCK;
                end
            end
            S_TM: begin
                if (btn_right) begin
                    state_n = S_AH;
                end else if (btn_left) begin
                    state_n = S_TH;
                end else if (btn_center) begin
                    state_n = S_CLOCK;
                end
            end
            S_AH: begin
                if (btn_right) begin
                    state_n = S_AM;
                end else if (btn_left) begin
                    if (sel_alarm != '0) begin
                        state_n = S_AM;
                        sel_n   = sel_alarm - 1'b1;
                    end else begin
                        state_n = S_TM;
                    end
                end else if (btn_center) begin
                    state_n = S_CLOCK;
                end
            end
            S_AM: begin
                if (btn_right) begin
                    if (sel_alarm < SEL_MAX) begin
                        state_n = S_AH;
                        sel_n   = sel_alarm + 1'b1;
                    end else begin
                        state_n = S_TH;
                        sel_n   = '0;
                    end
                end else if (btn_left) begin
                    state_n = S_AH;
                end else if (btn_center) begin
                    state_n = S_CLOCK;
                end
            end
            S_CLOCK: begin
                if (match) begin
                    state_n = S_RING;
                    rid_n   = hit_id;
                    fired_n = 1'b1;
                    left_n  = SNZ_INIT;
`ifdef MULTI_ALARM_RING_TIMEOUT_EN
                    ring_cnt_n = '0;
`endif
                end else if (btn_center) begin
                    state_n = S_TH;
                    sel_n   = '0;
                end
            end
            S_RING: begin
                snz_req = btn_center;
`ifdef MULTI_ALARM_RING_TIMEOUT_EN
                if (tick_sec && !btn_center) begin
                    if (ring_cnt == RING_LAST) begin
                        snz_req = 1'b1;
                    end else begin
                        ring_cnt_n = ring_cnt + 1'b1;
                    end
                end
`endif
                if (any_dir) begin
                    state_n = S_CLOCK;
                end else if (snz_req) begin
                    if (snooze_left != '0) begin
                        state_n   = S_SNOOZE;
                        left_n    = snooze_left - 1'b1;
                        snz_cnt_n = '0;
                    end else begin
                        state_n = S_CLOCK;
                    end
                end
            end
            S_SNOOZE: begin
                if (any_btn) begin
                    state_n = S_CLOCK;
                end else if (tick_sec) begin
                    if (snz_cnt == SNZ_LAST) begin
                        state_n = S_RING;
`ifdef MULTI_ALARM_RING_TIMEOUT_EN
                        ring_cnt_n = '0;
`endif
                    end else begin
                        snz_cnt_n = snz_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_TH;
                sel_n   = '0;
            end
        endcase
    end

    always_comb begin
        edit_n = 4'b0000;
        case (state_n)
            S_TH:    edit_n = 4'b1000;
            S_TM:    edit_n = 4'b0100;
            S_AH:    edit_n = 4'b0010;
            S_AM:    edit_n = 4'b0001;
            default: edit_n = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_TH;
            sel_alarm   <= '0;
            ring_id     <= '0;
            snooze_left <= SNZ_INIT;
            fired       <= 1'b0;
            snz_cnt     <= '0;
            adjust      <= 1'b1;
            edit_en     <= 4'b1000;
            ring        <= 1'b0;
            snoozing    <= 1'b0;
`ifdef MULTI_ALARM_RING_TIMEOUT_EN
            ring_cnt    <= '0;
`endif
        end else begin
            state       <= state_n;
            sel_alarm   <= sel_n;
            ring_id     <= rid_n;
            snooze_left <= left_n;
            fired       <= fired_n;
            snz_cnt     <= snz_cnt_n;
            adjust      <= (edit_n != 4'b0000);
            edit_en     <= edit_n;
            ring        <= (state_n == S_RING);
            snoozing    <= (state_n == S_SNOOZE);
`ifdef MULTI_ALARM_RING_TIMEOUT_EN
            ring_cnt    <= ring_cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_multi_alarm_fsm.sv
// Directed testbench for multi_alarm_fsm (N_ALARMS=2, defaults elsewhere).
module tb_multi_alarm_fsm;

    localparam logic [4:0] B_UP = 5'b10000;
    localparam logic [4:0] B_DN = 5'b01000;
    localparam logic [4:0] B_L  = 5'b00100;
    localparam logic [4:0] B_R  = 5'b00010;
    localparam logic [4:0] B_C  = 5'b00001;

    // status = {adjust, edit_en, sel_alarm, ring, snoozing}
    localparam logic [7:0] ST_TH   = 8'b1_1000_0_0_0;
    localparam logic [7:0] ST_TM   = 8'b1_0100_0_0_0;
    localparam logic [7:0] ST_AH0  = 8'b1_0010_0_0_0;
    localparam logic [7:0] ST_AM0  = 8'b1_0001_0_0_0;
    localparam logic [7:0] ST_AH1  = 8'b1_0010_1_0_0;
    localparam logic [7:0] ST_AM1  = 8'b1_0001_1_0_0;
    localparam logic [7:0] ST_CLK  = 8'b0_0000_0_0_0;
    localparam logic [7:0] ST_RING = 8'b0_0000_0_1_0;
    localparam logic [7:0] ST_SNZ  = 8'b0_0000_0_0_1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_sec = 1'b0;
    logic [4:0]  btns = 5'b0;
    logic [4:0]  time_h = 5'd12;
    logic [5:0]  time_m = 6'd0;
    logic [5:0]  time_s = 6'd1;
    logic [9:0]  alarm_h = {5'd7, 5'd7};
    logic [11:0] alarm_m = {6'd30, 6'd30};
    logic [1:0]  alarm_arm = 2'b10;

    logic        adjust, ring, snoozing;
    logic [3:0]  edit_en;
    logic [0:0]  sel_alarm, ring_id;
    logic [1:0]  snooze_left;
    logic [7:0]  st;

    int checks = 0;
    int errors = 0;

    assign st = {adjust, edit_en, sel_alarm, ring, snoozing};

    always #5 clk = ~clk;

    multi_alarm_fsm #(
        .N_ALARMS(2), .SNOOZE_SECS(30), .MAX_SNOOZE(3), .RING_TIMEOUT(60)
    ) dut (
        .clk(clk), .rst(rst), .tick_sec(tick_sec),
        .btn_up(btns[4]), .btn_down(btns[3]), .btn_left(btns[2]),
        .btn_right(btns[1]), .btn_center(btns[0]),
        .time_h(time_h), .time_m(time_m), .time_s(time_s),
        .alarm_h(alarm_h), .alarm_m(alarm_m), .alarm_arm(alarm_arm),
        .adjust(adjust), .edit_en(edit_en), .sel_alarm(sel_alarm),
        .ring(ring), .snoozing(snoozing), .ring_id(ring_id),
        .snooze_left(snooze_left)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] b);
        btns = b;
        cyc();
        btns = 5'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick_sec = 1'b1;
            cyc();
            tick_sec = 1'b0;
            cyc();
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++; if (st !== ST_TH) begin errors++; $display("FAIL reset_st: got %b want %b", st, ST_TH); end
        checks++; if (ring_id !== 1'b0) begin errors++; $display("FAIL reset_rid: got %b want 0", ring_id); end
        checks++; if (snooze_left !== 2'd3) begin errors++; $display("FAIL reset_left: got %0d want 3", snooze_left); end
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        checks++; if (st !== ST_TH) begin errors++; $display("FAIL reset_rel: got %b want %b", st, ST_TH); end
    endtask

    task automatic test_nav();
        press(B_R);
        checks++; if (st !== ST_TM) begin errors++; $display("FAIL nav_r1: got %b want %b", st, ST_TM); end
        press(B_R);
        checks++; if (st !== ST_AH0) begin errors++; $display("FAIL nav_r2: got %b want %b", st, ST_AH0); end
        press(B_R);
        checks++; if (st !== ST_AM0) begin errors++; $display("FAIL nav_r3: got %b want %b", st, ST_AM0); end
        press(B_R);
        checks++; if (st !== ST_AH1) begin errors++; $display("FAIL nav_r4: got %b want %b", st, ST_AH1); end
        press(B_L);
        checks++; if (st !== ST_AM0) begin errors++; $display("FAIL nav_l1: got %b want %b", st, ST_AM0); end
        press(B_L);
        checks++; if (st !== ST_AH0) begin errors++; $display("FAIL nav_l2: got %b want %b", st, ST_AH0); end
        press(B_R | B_L);
        checks++; if (st !== ST_AM0) begin errors++; $display("FAIL nav_prio_rl: got %b want %b", st, ST_AM0); end
        press(B_L);
        press(B_L | B_C);
        checks++; if (st !== ST_TM) begin errors++; $display("FAIL nav_prio_lc: got %b want %b", st, ST_TM); end
        press(B_C);
        checks++; if (st !== ST_CLK) begin errors++; $display("FAIL nav_center: got %b want %b", st, ST_CLK); end
    endtask

    task automatic test_match();
        time_h = 5'd7; time_m = 6'd30; time_s = 6'd0;
        cyc();
        checks++; if (st !== ST_RING) begin errors++; $display("FAIL match_ring: got %b want %b", st, ST_RING); end
        checks++; if (ring_id !== 1'b1) begin errors++; $display("FAIL match_rid: got %b want 1", ring_id); end
        checks++; if (snooze_left !== 2'd3) begin errors++; $display("FAIL match_left: got %0d want 3", snooze_left); end
        press(B_UP);
        checks++; if (st !== ST_CLK) begin errors++; $display("FAIL match_dismiss: got %b want %b", st, ST_CLK); end
        repeat (5) cyc();
        checks++; if (st !== ST_CLK) begin errors++; $display("FAIL match_noretrig: got %b want %b", st, ST_CLK); end
        time_s = 6'd1;
        cyc();
        alarm_arm = 2'b11;
        time_s = 6'd0;
        press(B_C);
        checks++; if (st !== ST_RING) begin errors++; $display("FAIL match_over_center: got %b want %b", st, ST_RING); end
        checks++; if (ring_id !== 1'b0) begin errors++; $display("FAIL match_lowest: got %b want 0", ring_id); end
        time_s = 6'd5;
        press(B_DN);
        checks++; if (st !== ST_CLK) begin errors++; $display("FAIL match_dn: got %b want %b", st, ST_CLK); end
    endtask

    task automatic test_snooze();
        time_s = 6'd0;
        cyc();
        time_s = 6'd5;
        checks++; if (st !== ST_RING) begin errors++; $display("FAIL snz_enter: got %b want %b", st, ST_RING); end
        press(B_C);
        checks++; if (st !== ST_SNZ) begin errors++; $display("FAIL snz_st: got %b want %b", st, ST_SNZ); end
        checks++; if (snooze_left !== 2'd2) begin errors++; $display("FAIL snz_left2: got %0d want 2", snooze_left); end
        ticks(29);
        checks++; if (st !== ST_SNZ) begin errors++; $display("FAIL snz_29: got %b want %b", st, ST_SNZ); end
        ticks(1);
        checks++; if (st !== ST_RING) begin errors++; $display("FAIL snz_30: got %b want %b", st, ST_RING); end
        checks++; if (ring_id !== 1'b0) begin errors++; $display("FAIL snz_rid: got %b want 0", ring_id); end
        press(B_C);
        checks++; if (snooze_left !== 2'd1) begin errors++; $display("FAIL snz_left1: got %0d want 1", snooze_left); end
        ticks(30);
        press(B_C);
        checks++; if (st !== ST_SNZ || snooze_left !== 2'd0) begin errors++; $display("FAIL snz_third: got %b/%0d want %b/0", st, snooze_left, ST_SNZ); end
        ticks(30);
        checks++; if (st !== ST_RING) begin errors++; $display("FAIL snz_ring3: got %b want %b", st, ST_RING); end
        press(B_C);
        checks++; if (st !== ST_CLK) begin errors++; $display("FAIL snz_exhaust: got %b want %b", st, ST_CLK); end
    endtask

    task automatic test_btn_wins();
        alarm_arm = 2'b10;
        time_s = 6'd0;
        cyc();
        time_s = 6'd5;
        checks++; if (ring_id !== 1'b1 || snooze_left !== 2'd3) begin errors++; $display("FAIL bw_enter: got rid %b left %0d want 1/3", ring_id, snooze_left); end
        press(B_C);
        ticks(29);
        tick_sec = 1'b1;
        btns = B_UP;
        cyc();
        tick_sec = 1'b0;
        btns = 5'b0;
        checks++; if (st !== ST_CLK) begin errors++; $display("FAIL bw_expiry: got %b want %b", st, ST_CLK); end
        cyc();
        checks++; if (st !== ST_CLK) begin errors++; $display("FAIL bw_stay: got %b want %b", st, ST_CLK); end
    endtask

    task automatic test_ring_timeout();
        time_s = 6'd0;
        cyc();
        time_s = 6'd5;
        checks++; if (st !== ST_RING) begin errors++; $display("FAIL to_enter: got %b want %b", st, ST_RING); end
`ifdef MULTI_ALARM_RING_TIMEOUT_EN
        ticks(59);
        checks++; if (st !== ST_RING) begin errors++; $display("FAIL to_59: got %b want %b", st, ST_RING); end
        ticks(1);
        checks++; if (st !== ST_SNZ || snooze_left !== 2'd2) begin errors++; $display("FAIL to_60: got %b/%0d want %b/2", st, snooze_left, ST_SNZ); end
        press(B_R);
`else
        ticks(200);
        checks++; if (st !== ST_RING) begin errors++; $display("FAIL to_none: got %b want %b", st, ST_RING); end
        press(B_L);
`endif
        checks++; if (st !== ST_CLK) begin errors++; $display("FAIL to_exit: got %b want %b", st, ST_CLK); end
    endtask

    task automatic test_reset_mid();
        time_s = 6'd0;
        cyc();
        time_s = 6'd5;
        checks++; if (ring !== 1'b1) begin errors++; $display("FAIL rm_ring: got %b want 1", ring); end
        #2 rst = 1'b1;
        #1;
        checks++; if (st !== ST_TH) begin errors++; $display("FAIL rm_async: got %b want %b", st, ST_TH); end
        checks++; if (ring_id !== 1'b0 || snooze_left !== 2'd3) begin errors++; $display("FAIL rm_regs: got %b/%0d want 0/3", ring_id, snooze_left); end
        cyc();
        rst = 1'b0;
        cyc();
        checks++; if (st !== ST_TH) begin errors++; $display("FAIL rm_rel: got %b want %b", st, ST_TH); end
    endtask

    task automatic test_wrap();
        press(B_L);
        checks++; if (st !== ST_AM1) begin errors++; $display("FAIL wrap_l: got %b want %b", st, ST_AM1); end
        press(B_L);
        checks++; if (st !== ST_AH1) begin errors++; $display("FAIL wrap_l2: got %b want %b", st, ST_AH1); end
        press(B_R);
        press(B_R);
        checks++; if (st !== ST_TH) begin errors++; $display("FAIL wrap_r: got %b want %b", st, ST_TH); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nav();
        test_match();
        test_snooze();
        test_btn_wins();
        test_ring_timeout();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
